// File: rtl/alu_arbiter.sv
// alu_arbiter: sequencer and two-port round-robin arbiter for the shared ALU.
//
// Accepts operation requests from two requesters over valid/ready handshakes,
// registers the winner's operands, holds them on the external combinational
// ALU for SETTLE cycles, captures the result and returns it to the granted
// requester over a response handshake.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid / req_ready [1:0]  per-requester request handshake
//   req_a, req_b                 operands, packed {req1, req0}
//   req_select                   4-bit ALU select per requester, {req1, req0}
//   req_mode, req_carry_in       ALU mode (1 = logic) and carry-in per requester
//   rsp_valid / rsp_ready [1:0]  per-requester response handshake
//   rsp_data, rsp_carry          captured ALU result, shared by both requesters
//   alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in
//                                operands driven to the ALU (registered)
//   alu_out, alu_carry_out       ALU result inputs
//   busy                         high whenever the sequencer is not idle
module alu_arbiter #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   input  logic [7:0]         req_select,
   input  logic [1:0]         req_mode,
   input  logic [1:0]         req_carry_in,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_data,
   output logic               rsp_carry,
   output logic [WIDTH-1:0]   alu_in_a,
   output logic [WIDTH-1:0]   alu_in_b,
   output logic [3:0]         alu_select,
   output logic               alu_mode,
   output logic               alu_carry_in,
   input  logic [WIDTH-1:0]   alu_out,
   input  logic               alu_carry_out,
   output logic               busy
);

   localparam int unsigned SEL_W = 4;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // One ALU operation as latched from the winning requester
   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [SEL_W-1:0] sel;
      logic             mode;
      logic             cin;
   } op_t;

   state_t           state_q;
   state_t           state_d;
   logic             ptr_q;
   logic             gnt_q;
   logic [CNT_W-1:0] cnt_q;
   op_t              op_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_carry_q;
   logic [1:0]       rsp_valid_q;
   logic             busy_q;

   logic             gnt_c;
   op_t              op_sel_c;
   logic             grant_c;
   logic             settle_done_c;
   logic             rsp_hs_c;

   // Winner selection: pointer holder on contention, otherwise the lone requester
   always_comb begin
      gnt_c = 1'b0;
      if (req_valid == 2'b11) begin
         gnt_c = ptr_q;
      end else begin
         gnt_c = req_valid[1];
      end
   end

   // Operand mux from the winning requester's lanes
   always_comb begin
      op_sel_c = '0;
      if (gnt_c) begin
         op_sel_c.a    = req_a[2*WIDTH-1:WIDTH];
         op_sel_c.b    = req_b[2*WIDTH-1:WIDTH];
         op_sel_c.sel  = req_select[2*SEL_W-1:SEL_W];
         op_sel_c.mode = req_mode[1];
         op_sel_c.cin  = req_carry_in[1];
      end else begin
         op_sel_c.a    = req_a[WIDTH-1:0];
         op_sel_c.b    = req_b[WIDTH-1:0];
         op_sel_c.sel  = req_select[SEL_W-1:0];
         op_sel_c.mode = req_mode[0];
         op_sel_c.cin  = req_carry_in[0];
      end
   end

   assign grant_c       = (state_q == IDLE) && (|req_valid);
   // Counter was cleared on grant, so SETTLE-1 marks the last EXEC cycle
   assign settle_done_c = (state_q == EXEC) && (cnt_q == CNT_W'(SETTLE - 1));
   assign rsp_hs_c      = (state_q == RESP) && rsp_ready[gnt_q];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and request-accept decode; req_ready answers in the request cycle
   always_comb begin
      state_d   = state_q;
      req_ready = 2'b00;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready = gnt_c ? 2'b10 : 2'b01;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            if (settle_done_c) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready[gnt_q]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand registers, grant owner and settle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= '0;
         gnt_q <= 1'b0;
         cnt_q <= '0;
      end else if (grant_c) begin
         op_q  <= op_sel_c;
         gnt_q <= gnt_c;
         cnt_q <= '0;
      end else if (state_q == EXEC) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Result capture at the end of the settle window; held through RESP and beyond
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
      end else if (settle_done_c) begin
         rsp_data_q  <= alu_out;
         rsp_carry_q <= alu_carry_out;
      end
   end

   // Response valid, busy flag and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 2'b00;
         busy_q      <= 1'b0;
         ptr_q       <= 1'b0;
      end else begin
         if (grant_c) begin
            busy_q <= 1'b1;
         end
         if (settle_done_c) begin
            rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
         end
         if (rsp_hs_c) begin
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            ptr_q       <= ~gnt_q;
         end
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_carry    = rsp_carry_q;
   assign busy         = busy_q;
   assign alu_in_a     = op_q.a;
   assign alu_in_b     = op_q.b;
   assign alu_select   = op_q.sel;
   assign alu_mode     = op_q.mode;
   assign alu_carry_in = op_q.cin;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter. Two instances (SETTLE = 1 and
// SETTLE = 3), each with a small ALU model attached, checked every cycle
// against a transaction-level model plus hand-computed expectations.
module tb_alu_arbiter;

   localparam int unsigned W      = 16;
   localparam int unsigned S_FAST = 1;
   localparam int unsigned S_SLOW = 3;

   logic clk = 1'b0;
   logic rst_n;

   logic [1:0]     req_valid    [2];
   logic [1:0]     req_ready    [2];
   logic [2*W-1:0] req_a        [2];
   logic [2*W-1:0] req_b        [2];
   logic [7:0]     req_select   [2];
   logic [1:0]     req_mode     [2];
   logic [1:0]     req_carry_in [2];
   logic [1:0]     rsp_valid    [2];
   logic [1:0]     rsp_ready    [2];
   logic [W-1:0]   rsp_data     [2];
   logic           rsp_carry    [2];
   logic [W-1:0]   alu_in_a     [2];
   logic [W-1:0]   alu_in_b     [2];
   logic [3:0]     alu_select   [2];
   logic           alu_mode     [2];
   logic           alu_carry_in [2];
   logic [W-1:0]   alu_out      [2];
   logic           alu_carry_out[2];
   logic           busy         [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic int settle_of(input int k);
      return (k == 0) ? int'(S_FAST) : int'(S_SLOW);
   endfunction

   // Small ALU: enough of the select space to exercise add, subtract and logic ops
   function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] s, input logic m, input logic c);
      logic [W:0] r;
      r = '0;
      if (m) begin
         case (s)
            4'b0110: r = {1'b0, a ^ b};
            4'b1011: r = {1'b0, a & b};
            4'b1110: r = {1'b0, a | b};
            4'b0000: r = {1'b0, ~a};
            default: r = '0;
         endcase
      end else begin
         case (s)
            4'b1001: r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            4'b0110: r = {1'b0, a} + {1'b0, ~b} + (W+1)'(c);
            default: r = {1'b0, a} + (W+1)'(c);
         endcase
      end
      return r;
   endfunction

   function automatic int pick(input logic [1:0] v, input int ptr);
      if (v == 2'b11) return ptr;
      return v[1] ? 1 : 0;
   endfunction

   generate
      for (genvar k = 0; k < 2; k++) begin : g_dut
         alu_arbiter #(
            .WIDTH (W),
            .SETTLE((k == 0) ? S_FAST : S_SLOW)
         ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid    (req_valid[k]),
            .req_ready    (req_ready[k]),
            .req_a        (req_a[k]),
            .req_b        (req_b[k]),
            .req_select   (req_select[k]),
            .req_mode     (req_mode[k]),
            .req_carry_in (req_carry_in[k]),
            .rsp_valid    (rsp_valid[k]),
            .rsp_ready    (rsp_ready[k]),
            .rsp_data     (rsp_data[k]),
            .rsp_carry    (rsp_carry[k]),
            .alu_in_a     (alu_in_a[k]),
            .alu_in_b     (alu_in_b[k]),
            .alu_select   (alu_select[k]),
            .alu_mode     (alu_mode[k]),
            .alu_carry_in (alu_carry_in[k]),
            .alu_out      (alu_out[k]),
            .alu_carry_out(alu_carry_out[k]),
            .busy         (busy[k])
         );
         assign {alu_carry_out[k], alu_out[k]} =
            alu_fn(alu_in_a[k], alu_in_b[k], alu_select[k], alu_mode[k], alu_carry_in[k]);
      end
   endgenerate

   // Transaction model: m_age counts cycles since the grant edge (1 = first EXEC cycle)
   bit           m_busy [2];
   int           m_age  [2];
   int           m_g    [2];
   int           m_ptr  [2];
   logic [W-1:0] m_a    [2];
   logic [W-1:0] m_b    [2];
   logic [3:0]   m_sel  [2];
   logic         m_mode [2];
   logic         m_cin  [2];
   logic [W:0]   m_res  [2];
   logic [W:0]   m_cap  [2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_busy[k] <= 1'b0;
            m_age[k]  <= 0;
            m_g[k]    <= 0;
            m_ptr[k]  <= 0;
            m_a[k]    <= '0;
            m_b[k]    <= '0;
            m_sel[k]  <= '0;
            m_mode[k] <= 1'b0;
            m_cin[k]  <= 1'b0;
            m_res[k]  <= '0;
            m_cap[k]  <= '0;
         end else if (!m_busy[k]) begin
            if (req_valid[k] != 2'b00) begin
               m_busy[k] <= 1'b1;
               m_age[k]  <= 1;
               m_g[k]    <= pick(req_valid[k], m_ptr[k]);
               m_a[k]    <= req_a[k][pick(req_valid[k], m_ptr[k])*W +: W];
               m_b[k]    <= req_b[k][pick(req_valid[k], m_ptr[k])*W +: W];
               m_sel[k]  <= req_select[k][pick(req_valid[k], m_ptr[k])*4 +: 4];
               m_mode[k] <= req_mode[k][pick(req_valid[k], m_ptr[k])];
               m_cin[k]  <= req_carry_in[k][pick(req_valid[k], m_ptr[k])];
               m_res[k]  <= alu_fn(req_a[k][pick(req_valid[k], m_ptr[k])*W +: W],
                                   req_b[k][pick(req_valid[k], m_ptr[k])*W +: W],
                                   req_select[k][pick(req_valid[k], m_ptr[k])*4 +: 4],
                                   req_mode[k][pick(req_valid[k], m_ptr[k])],
                                   req_carry_in[k][pick(req_valid[k], m_ptr[k])]);
            end
         end else if (m_age[k] > settle_of(k)) begin
            if (rsp_ready[k][m_g[k]]) begin
               m_busy[k] <= 1'b0;
               m_ptr[k]  <= 1 - m_g[k];
            end
         end else begin
            m_age[k] <= m_age[k] + 1;
            if (m_age[k] + 1 > settle_of(k)) m_cap[k] <= m_res[k];
         end
      end
   end

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d t=%0t: got %h, expected %h", name, k, $time, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name, input int k);
      n_vec++;
      n_err++;
      $display("FAIL %s dut%0d t=%0t: wait bound expired", name, k, $time);
   endtask

   // Per-cycle comparison of both instances against the model
   task automatic cmp_cycle();
      logic [1:0] er;
      logic [1:0] ev;
      for (int k = 0; k < 2; k++) begin
         er = 2'b00;
         ev = 2'b00;
         if (!m_busy[k] && req_valid[k] != 2'b00)
            er = (pick(req_valid[k], m_ptr[k]) == 1) ? 2'b10 : 2'b01;
         if (m_busy[k] && m_age[k] > settle_of(k))
            ev = (m_g[k] == 1) ? 2'b10 : 2'b01;
         chk("req_ready", k, 32'(req_ready[k]), 32'(er));
         chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(ev));
         chk("busy",      k, 32'(busy[k]),      32'(m_busy[k]));
         chk("rsp_data",  k, 32'(rsp_data[k]),  32'(m_cap[k][W-1:0]));
         chk("rsp_carry", k, 32'(rsp_carry[k]), 32'(m_cap[k][W]));
         if (m_busy[k] && m_age[k] <= settle_of(k)) begin
            chk("alu_in_a",     k, 32'(alu_in_a[k]),     32'(m_a[k]));
            chk("alu_in_b",     k, 32'(alu_in_b[k]),     32'(m_b[k]));
            chk("alu_select",   k, 32'(alu_select[k]),   32'(m_sel[k]));
            chk("alu_mode",     k, 32'(alu_mode[k]),     32'(m_mode[k]));
            chk("alu_carry_in", k, 32'(alu_carry_in[k]), 32'(m_cin[k]));
         end
      end
   endtask

   // Advance to the next falling edge, compare, then step past it for driving
   task automatic tick();
      @(negedge clk);
      cmp_cycle();
      #1;
   endtask

   task automatic set_req(input int k, input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] sel, input logic mode, input logic cin);
      req_a[k][r*W +: W]        = a;
      req_b[k][r*W +: W]        = b;
      req_select[k][r*4 +: 4]   = sel;
      req_mode[k][r]            = mode;
      req_carry_in[k][r]        = cin;
      req_valid[k][r]           = 1'b1;
   endtask

   // Returns after the handshake edge, in the first EXEC cycle
   task automatic wait_grant(input int k, input int r, output logic [1:0] rdy);
      rdy = 2'b00;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (req_ready[k][r]) begin
            rdy = req_ready[k];
            tick();
            return;
         end
         tick();
      end
      timeout_fail("grant_wait", k);
   endtask

   // Cycles after the handshake edge until rsp_valid is seen
   task automatic wait_rsp(input int k, output int lat);
      lat = 1;
      while (rsp_valid[k] == 2'b00 && lat < 40) begin
         tick();
         lat++;
      end
      if (rsp_valid[k] == 2'b00) timeout_fail("rsp_wait", k);
   endtask

   task automatic drain(input int k);
      req_valid[k] = 2'b00;
      for (int i = 0; i < 40; i++) begin
         if (!busy[k] && rsp_valid[k] == 2'b00) return;
         tick();
      end
      timeout_fail("drain", k);
   endtask

   task automatic run_op(input int k, input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] sel, input logic mode, input logic cin,
                         input logic [1:0] exp_onehot, input logic [W-1:0] exp_data,
                         input logic exp_carry);
      logic [1:0] rdy;
      int         lat;
      set_req(k, r, a, b, sel, mode, cin);
      wait_grant(k, r, rdy);
      chk("lit_req_ready", k, 32'(rdy), 32'(exp_onehot));
      req_valid[k][r] = 1'b0;
      wait_rsp(k, lat);
      chk("lit_latency",   k, 32'(lat), 32'(settle_of(k) + 1));
      chk("lit_rsp_valid", k, 32'(rsp_valid[k]), 32'(exp_onehot));
      chk("lit_rsp_data",  k, 32'(rsp_data[k]),  32'(exp_data));
      chk("lit_rsp_carry", k, 32'(rsp_carry[k]), 32'(exp_carry));
      tick();
      chk("lit_idle_busy", k, 32'(busy[k]), 32'(0));
   endtask

   initial begin
      logic [1:0] rdy;
      int         lat;
      int         n;
      int         grants[4];

      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req_valid[k]    = 2'b00;
         req_a[k]        = '0;
         req_b[k]        = '0;
         req_select[k]   = '0;
         req_mode[k]     = 2'b00;
         req_carry_in[k] = 2'b00;
         rsp_ready[k]    = 2'b11;
      end
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("rst_busy",      k, 32'(busy[k]),      32'(0));
         chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'(0));
         chk("rst_rsp_data",  k, 32'(rsp_data[k]),  32'(0));
         chk("rst_alu_in_a",  k, 32'(alu_in_a[k]),  32'(0));
      end
      rst_n = 1'b1;
      tick();

      // Add with carry-in, carry out, XOR, subtract
      run_op(0, 0, 16'h0001, 16'h0002, 4'b1001, 1'b0, 1'b1, 2'b01, 16'h0004, 1'b0);
      run_op(0, 1, 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 2'b10, 16'h0000, 1'b1);
      run_op(0, 0, 16'hF0F0, 16'h0FF0, 4'b0110, 1'b1, 1'b0, 2'b01, 16'hFF00, 1'b0);
      run_op(1, 1, 16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b1, 2'b10, 16'h0002, 1'b1);

      // Fairness: both valid continuously from reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      set_req(0, 0, 16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0);
      set_req(0, 1, 16'h00FF, 16'h0F0F, 4'b0110, 1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 80 && n < 4; i++) begin
         #1;
         if (req_ready[0] != 2'b00) begin
            grants[n] = req_ready[0][1] ? 1 : 0;
            n++;
         end
         tick();
      end
      chk("fair_count", 0, 32'(n), 32'(4));
      for (int i = 0; i < 4; i++) chk("fair_grant", 0, 32'(grants[i]), 32'(i % 2));
      drain(0);

      // Response back-pressure on the SETTLE = 3 instance
      rsp_ready[1] = 2'b00;
      set_req(1, 0, 16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0);
      wait_grant(1, 0, rdy);
      chk("bp_req_ready", 1, 32'(rdy), 32'(2'b01));
      req_valid[1][0] = 1'b0;
      wait_rsp(1, lat);
      chk("bp_latency", 1, 32'(lat), 32'(4));
      set_req(1, 1, 16'h00FF, 16'h0F0F, 4'b0110, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_req_ready_held", 1, 32'(req_ready[1]), 32'(2'b00));
         chk("bp_rsp_valid_held", 1, 32'(rsp_valid[1]), 32'(2'b01));
         chk("bp_rsp_data_held",  1, 32'(rsp_data[1]),  32'(16'h2345));
         tick();
      end
      rsp_ready[1] = 2'b01;
      tick();
      chk("bp_idle_busy",      1, 32'(busy[1]),      32'(0));
      chk("bp_idle_rsp_valid", 1, 32'(rsp_valid[1]), 32'(2'b00));
      rsp_ready[1] = 2'b11;
      wait_grant(1, 1, rdy);
      chk("bp_next_grant", 1, 32'(rdy), 32'(2'b10));
      req_valid[1][1] = 1'b0;
      wait_rsp(1, lat);
      chk("bp_next_data", 1, 32'(rsp_data[1]), 32'(16'h0FF0));
      tick();

      // Move pointer to 1, then abort an operation with reset mid-EXEC
      run_op(1, 0, 16'h0010, 16'h0020, 4'b1110, 1'b1, 1'b0, 2'b01, 16'h0030, 1'b0);
      set_req(1, 0, 16'h0007, 16'h0008, 4'b1001, 1'b0, 1'b0);
      wait_grant(1, 0, rdy);
      req_valid[1][0] = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("abort_busy",      1, 32'(busy[1]),      32'(0));
      chk("abort_rsp_valid", 1, 32'(rsp_valid[1]), 32'(2'b00));
      chk("abort_req_ready", 1, 32'(req_ready[1]), 32'(2'b00));
      chk("abort_rsp_data",  1, 32'(rsp_data[1]),  32'(16'h0000));
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("abort_no_rsp", 1, 32'(rsp_valid[1]), 32'(2'b00));
         tick();
      end
      set_req(1, 0, 16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b0);
      set_req(1, 1, 16'h0003, 16'h0004, 4'b1011, 1'b1, 1'b0);
      #1;
      chk("abort_ptr_reset", 1, 32'(req_ready[1]), 32'(2'b01));
      tick();
      drain(1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
